// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: opcode constants, state and class enums, and mux-select encodings for the LEGv8 multicycle controller.
package legv8_ctrl_pkg;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] MASK_CB = 11'b11111111000;
  localparam logic [10:0] MASK_B  = 11'b11111100000;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU, S_MEM_ADDR, S_MEM_READ,
    S_WB_MEM, S_MEM_WRITE, S_BR_COND, S_BR_UNCOND, S_HALT
  } state_e;
  typedef enum logic [1:0] {SIGN_D = 2'b00, SIGN_B = 2'b01, SIGN_CB = 2'b10, SIGN_X = 2'b11} sign_op_e;
  typedef enum logic [1:0] {A_PC = 2'b00, A_REG = 2'b01, A_OLDPC = 2'b10} alu_src_a_e;
  typedef enum logic [1:0] {B_REG = 2'b00, B_FOUR = 2'b01, B_SEXT = 2'b10, B_SEXT2 = 2'b11} alu_src_b_e;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_PASSB = 2'b01, ALU_FUNC = 2'b10} alu_op_e;
  typedef enum logic [2:0] {C_R, C_LOAD, C_STORE, C_CBZ, C_CBNZ, C_B, C_ILLEGAL} iclass_e;
endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: combinational map from IR[31:21] to instruction class.
module opcode_classifier
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] Opcode,
  output iclass_e     cls_o
);
  logic is_r;
  always_comb begin
    is_r  = (Opcode == OP_ADD) || (Opcode == OP_SUB) || (Opcode == OP_AND) || (Opcode == OP_ORR);
    cls_o = is_r                                ? C_R     :
            (Opcode == OP_LDUR)                 ? C_LOAD  :
            (Opcode == OP_STUR)                 ? C_STORE :
            ((Opcode & MASK_CB) == OP_CBZ)      ? C_CBZ   :
            ((Opcode & MASK_CB) == OP_CBNZ)     ? C_CBNZ  :
            ((Opcode & MASK_B) == OP_B)         ? C_B     : C_ILLEGAL;
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: LEGv8 multicycle control FSM with memory handshake and retired-instruction counter.
module multicycle_controller
  import legv8_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [10:0]      Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             Reg2Loc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       SignOp,
  output logic             Halted,
  output logic [CNT_W-1:0] InstrRetired
);
  state_e            state_q, state_d;
  iclass_e           cls;
  logic              retire;
  logic [CNT_W-1:0]  cnt_q;

  opcode_classifier u_cls (.Opcode(Opcode), .cls_o(cls));

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrcA  = A_PC;
    ALUSrcB  = B_REG;
    ALUOp    = ALU_ADD;
    SignOp   = SIGN_D;
    Halted   = 1'b0;
    // Reset forces the fetch request shape but suppresses every write
    if (Reset) begin
      MemRead = 1'b1;
      ALUSrcB = B_FOUR;
    end else begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = B_FOUR;
          IRWrite = MemReady;
          PCWrite = MemReady;
          state_d = MemReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcA = A_OLDPC;
          ALUSrcB = B_SEXT2;
          SignOp  = (cls == C_B) ? SIGN_B :
                    (cls == C_CBZ || cls == C_CBNZ) ? SIGN_CB :
                    (cls == C_LOAD || cls == C_STORE) ? SIGN_D : SIGN_X;
          state_d = (cls == C_R) ? S_EXEC_R :
                    (cls == C_LOAD || cls == C_STORE) ? S_MEM_ADDR :
                    (cls == C_CBZ || cls == C_CBNZ) ? S_BR_COND :
                    (cls == C_B) ? S_BR_UNCOND : S_HALT;
        end
        S_EXEC_R: begin
          ALUSrcA = A_REG;
          ALUOp   = ALU_FUNC;
          state_d = S_WB_ALU;
        end
        S_WB_ALU: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEM_ADDR: begin
          ALUSrcA = A_REG;
          ALUSrcB = B_SEXT;
          state_d = (cls == C_LOAD) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = MemReady ? S_WB_MEM : S_MEM_READ;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEM_WRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          Reg2Loc  = 1'b1;
          retire   = MemReady;
          state_d  = MemReady ? S_FETCH : S_MEM_WRITE;
        end
        S_BR_COND: begin
          Reg2Loc = 1'b1;
          ALUOp   = ALU_PASSB;
          PCSrc   = 1'b1;
          PCWrite = (cls == C_CBZ) ? Zero : ~Zero;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_BR_UNCOND: begin
          PCWrite = 1'b1;
          PCSrc   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        default: Halted = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end
  end

  assign InstrRetired = cnt_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized and directed checks against an instruction-level control-sequence model.
module tb_multicycle_controller;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [10:0] Opcode = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc, Halted;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, SignOp;
  logic [31:0] InstrRetired;
  logic [31:0] exp_cnt = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  multicycle_controller #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .SignOp(SignOp), .Halted(Halted), .InstrRetired(InstrRetired)
  );

  always #5 CLK = ~CLK;

  // {PCWrite,PCSrc,IRWrite,IorD,MemRead,MemWrite,RegWrite,MemtoReg,Reg2Loc,ALUSrcA,ALUSrcB,ALUOp,SignOp,Halted}
  function automatic logic [17:0] v(input logic pcw, pcs, irw, iord, mr, mw, rw, m2r, r2l,
                                    input logic [1:0] a, b, op, so, input logic h);
    return {pcw, pcs, irw, iord, mr, mw, rw, m2r, r2l, a, b, op, so, h};
  endfunction

  function automatic logic [17:0] outs();
    return {PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc,
            ALUSrcA, ALUSrcB, ALUOp, SignOp, Halted};
  endfunction

  // 0=R 1=LDUR 2=STUR 3=CBZ 4=CBNZ 5=B 6=illegal
  function automatic int cls(input logic [10:0] o);
    if (o == 11'b10001011000 || o == 11'b11001011000 || o == 11'b10001010000 || o == 11'b10101010000) return 0;
    if (o == 11'b11111000010) return 1;
    if (o == 11'b11111000000) return 2;
    if (o[10:3] == 8'b10110100) return 3;
    if (o[10:3] == 8'b10110101) return 4;
    if (o[10:5] == 6'b000101) return 5;
    return 6;
  endfunction

  function automatic logic [10:0] rand_legal();
    logic [10:0] r_ops [4];
    logic [2:0]  lo3;
    logic [4:0]  lo5;
    r_ops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    lo3 = 3'($urandom);
    lo5 = 5'($urandom);
    case ($urandom_range(0, 8))
      0, 1, 2, 3: return r_ops[$urandom_range(0, 3)];
      4: return 11'b11111000010;
      5: return 11'b11111000000;
      6: return {8'b10110100, lo3};
      7: return {8'b10110101, lo3};
      default: return {6'b000101, lo5};
    endcase
  endfunction

  // Builds the expected per-cycle control sequence for one instruction and plays it; cut>=0 stops early.
  task automatic run_instr(input string name, input logic [10:0] op, input int fw, input int mw,
                           input logic z, input int cut);
    logic [17:0] eq[$];
    bit          rq[$];
    logic [1:0]  so;
    int          c;
    int          n;
    c  = cls(op);
    so = (c == 5) ? 2'b01 : (c == 3 || c == 4) ? 2'b10 : (c == 1 || c == 2) ? 2'b00 : 2'b11;
    for (int i = 0; i < fw; i++) begin eq.push_back(v(0,0,0,0,1,0,0,0,0,2'b00,2'b01,2'b00,2'b00,0)); rq.push_back(0); end
    eq.push_back(v(1,0,1,0,1,0,0,0,0,2'b00,2'b01,2'b00,2'b00,0)); rq.push_back(1);
    eq.push_back(v(0,0,0,0,0,0,0,0,0,2'b10,2'b11,2'b00,so,0)); rq.push_back(1'($urandom));
    if (c == 0) begin
      eq.push_back(v(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b10,2'b00,0)); rq.push_back(1'($urandom));
      eq.push_back(v(0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0)); rq.push_back(1'($urandom));
    end else if (c == 1 || c == 2) begin
      eq.push_back(v(0,0,0,0,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,0)); rq.push_back(1'($urandom));
      for (int i = 0; i <= mw; i++) begin
        eq.push_back(c == 1 ? v(0,0,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0)
                            : v(0,0,0,1,0,1,0,0,1,2'b00,2'b00,2'b00,2'b00,0));
        rq.push_back(i == mw);
      end
      if (c == 1) begin eq.push_back(v(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0)); rq.push_back(1'($urandom)); end
    end else if (c == 3 || c == 4) begin
      eq.push_back(v((c == 3) ? z : !z,1,0,0,0,0,0,0,1,2'b00,2'b00,2'b01,2'b00,0)); rq.push_back(1'($urandom));
    end else if (c == 5) begin
      eq.push_back(v(1,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0)); rq.push_back(1'($urandom));
    end else begin
      for (int i = 0; i < 20; i++) begin eq.push_back(v(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1)); rq.push_back(1'($urandom)); end
    end
    n = (cut >= 0 && cut < eq.size()) ? cut : eq.size();
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      Opcode = op; Zero = z; MemReady = rq[i];
      #1;
      n_cmp++;
      if (outs() !== eq[i]) begin
        n_err++;
        $display("FAIL %s cyc%0d ctrl: got %b expected %b", name, i, outs(), eq[i]);
      end
    end
    if (cut < 0 && c != 6) begin
      exp_cnt = exp_cnt + 1;
      @(posedge CLK); #1;
      n_cmp++;
      if (InstrRetired !== exp_cnt) begin
        n_err++;
        $display("FAIL %s retired: got %0d expected %0d", name, InstrRetired, exp_cnt);
      end
    end
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge CLK);
    Reset = 1'b1; MemReady = rdy;
    #1;
    n_cmp++;
    if (outs() !== v(0,0,0,0,1,0,0,0,0,2'b00,2'b01,2'b00,2'b00,0)) begin
      n_err++;
      $display("FAIL reset_cycle ctrl: got %b", outs());
    end
    @(negedge CLK);
    Reset = 1'b0; MemReady = 1'b0;
    #1;
    exp_cnt = '0;
    n_cmp++;
    if (outs() !== v(0,0,0,0,1,0,0,0,0,2'b00,2'b01,2'b00,2'b00,0) || InstrRetired !== 32'd0) begin
      n_err++;
      $display("FAIL post_reset: ctrl %b retired %0d expected fetch and 0", outs(), InstrRetired);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1);
  endtask

  task automatic test_add();
    run_instr("add", 11'b10001011000, 0, 0, 1'b0, -1);
  endtask

  task automatic test_ldur_wait();
    run_instr("ldur_wait", 11'b11111000010, 0, 3, 1'b0, -1);
  endtask

  task automatic test_cb();
    run_instr("cbz_z1", 11'b10110100101, 1, 0, 1'b1, -1);
    run_instr("cbnz_z1", 11'b10110101011, 0, 0, 1'b1, -1);
  endtask

  task automatic test_stur_b();
    run_instr("stur", 11'b11111000000, 0, 1, 1'b0, -1);
    run_instr("b", 11'b00010110110, 2, 0, 1'b0, -1);
  endtask

  task automatic test_halt();
    run_instr("halt", 11'b11111111111, 0, 0, 1'b0, -1);
    do_reset(1'b0);
  endtask

  task automatic test_reset_mid();
    run_instr("stur_cut", 11'b11111000000, 0, 3, 1'b0, 5);
    do_reset(1'b1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++)
      run_instr("rand", rand_legal(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    test_reset();
    test_add();
    test_ldur_wait();
    test_cb();
    test_stur_b();
    test_random();
    test_halt();
    test_reset_mid();
    test_add();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
